// File: rtl/hazard_pkg.sv
// Shared defaults, width helpers and latency type for the hazard scoreboard.
package hazard_pkg;
  localparam int NREG_DEF    = 32;
  localparam int MAX_LAT_DEF = 8;

  function automatic int aw_f(input int nreg);
    return $clog2(nreg);
  endfunction

  function automatic int lw_f(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  typedef logic [lw_f(MAX_LAT_DEF)-1:0] lat_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side issue/hazard bundle between the pipeline and the scoreboard.
// StallD is a combinational response to the Decode inputs of the same cycle;
// an issue is accepted only in a cycle where IssueValidD is high and StallD is low.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int MAX_LAT = MAX_LAT_DEF
);
  localparam int AW = aw_f(NREG);
  localparam int LW = lw_f(MAX_LAT);

  logic            IssueValidD;
  logic            RegWriteD;
  logic [AW-1:0]   RdD;
  logic [LW-1:0]   LatD;
  logic [AW-1:0]   Rs1D;
  logic [AW-1:0]   Rs2D;
  logic            FlushE;
  logic            StallD;
  logic [NREG-1:0] BusyVec;
  logic [AW:0]     BusyCount;
  logic [31:0]     StallCycles;

  modport master (
    output IssueValidD, RegWriteD, RdD, LatD, Rs1D, Rs2D, FlushE,
    input  StallD, BusyVec, BusyCount, StallCycles
  );

  modport slave (
    input  IssueValidD, RegWriteD, RdD, LatD, Rs1D, Rs2D, FlushE,
    output StallD, BusyVec, BusyCount, StallCycles
  );
endinterface

// File: rtl/sb_entry.sv
// One register's result-latency counter: load beats flush-clear beats decrement.
module sb_entry #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [LW-1:0] lat_i,
  input  logic          clear_i,
  output logic [LW-1:0] cnt_o
);
  logic [LW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = lat_i;
    else if (clear_i)
      cnt_d = '0;
    else if (cnt_q != '0)
      cnt_d = cnt_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register busy scoreboard producing the Decode stall for RAW/WAW hazards.
// Define HAZARD_SCOREBOARD_FWD_EN to treat a result in its final cycle as forwarded.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int MAX_LAT = MAX_LAT_DEF
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);
  localparam int AW = aw_f(NREG);
  localparam int LW = lw_f(MAX_LAT);
`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam logic [LW-1:0] AVAIL_THR = LW'(1);
`else
  localparam logic [LW-1:0] AVAIL_THR = '0;
`endif

  logic [NREG-1:0][LW-1:0] cnt;
  logic [NREG-1:0]         busy;
  logic                    raw1, raw2, waw, stall, accept;
  logic [LW-1:0]           lat_clamped;
  logic                    last_v_q, last_v_d;
  logic [AW-1:0]           last_rd_q, last_rd_d;
  logic [AW:0]             busy_cnt_q, busy_cnt_d;
  logic [31:0]             stall_cyc_q, stall_cyc_d;

  always_comb begin
    raw1        = (bus.Rs1D != '0) && (cnt[bus.Rs1D] > AVAIL_THR);
    raw2        = (bus.Rs2D != '0) && (cnt[bus.Rs2D] > AVAIL_THR);
    waw         = bus.RegWriteD && (bus.RdD != '0) && (cnt[bus.RdD] != '0);
    stall       = bus.IssueValidD && (raw1 || raw2 || waw);
    accept      = bus.IssueValidD && !stall && bus.RegWriteD &&
                  (bus.RdD != '0) && (bus.LatD != '0);
    lat_clamped = (bus.LatD > LW'(MAX_LAT)) ? LW'(MAX_LAT) : bus.LatD;
  end

  // Register 0 never becomes busy, so it has no counter instance.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(.LW(LW)) u_entry (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept && (bus.RdD == AW'(r))),
      .lat_i   (lat_clamped),
      .clear_i (bus.FlushE && last_v_q && (last_rd_q == AW'(r))),
      .cnt_o   (cnt[r])
    );
  end

  always_comb begin
    busy       = '0;
    busy_cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      busy[r]    = (cnt[r] != '0);
      busy_cnt_d = busy_cnt_d + (AW+1)'(busy[r]);
    end
    last_v_d    = accept;
    last_rd_d   = bus.RdD;
    stall_cyc_d = stall_cyc_q;
    if (stall && (stall_cyc_q != '1))
      stall_cyc_d = stall_cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_v_q    <= 1'b0;
      last_rd_q   <= '0;
      busy_cnt_q  <= '0;
      stall_cyc_q <= '0;
    end else begin
      last_v_q    <= last_v_d;
      last_rd_q   <= last_rd_d;
      busy_cnt_q  <= busy_cnt_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign bus.StallD      = stall;
  assign bus.BusyVec     = busy;
  assign bus.BusyCount   = busy_cnt_q;
  assign bus.StallCycles = stall_cyc_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed hazard scenarios plus random traffic vs a behavioural model.
module tb_hazard_scoreboard;
  localparam int NREG    = 32;
  localparam int MAX_LAT = 8;
`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam int THR = 1;
`else
  localparam int THR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NREG), .MAX_LAT(MAX_LAT)) b ();

  hazard_scoreboard #(.NREG(NREG), .MAX_LAT(MAX_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: remaining cycles until each register's result is usable.
  int          cnt_m [NREG];
  bit          last_v_m;
  int          last_rd_m;
  int          bc_m;
  longint      sc_m;
  logic        obs_stall;
  logic [NREG-1:0] obs_busy;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input bit iv, input bit rw, input int rd, input int lat,
                       input int rs1, input int rs2, input bit fl);
    b.IssueValidD = iv;
    b.RegWriteD   = rw;
    b.RdD         = 5'(rd);
    b.LatD        = 4'(lat);
    b.Rs1D        = 5'(rs1);
    b.Rs2D        = 5'(rs2);
    b.FlushE      = fl;
  endtask

  function automatic bit src_blocked(input int s);
    return (s != 0) && (cnt_m[s] > THR);
  endfunction

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic tick();
    bit exp_stall, acc;
    logic [NREG-1:0] exp_busy;
    int rd, lat, pop;
    @(negedge clk);
    rd  = int'(b.RdD);
    lat = int'(b.LatD);
    exp_stall = b.IssueValidD && (src_blocked(int'(b.Rs1D)) || src_blocked(int'(b.Rs2D)) ||
                (b.RegWriteD && rd != 0 && cnt_m[rd] != 0));
    exp_busy = '0;
    pop = 0;
    for (int r = 0; r < NREG; r++) begin
      exp_busy[r] = (cnt_m[r] != 0);
      if (cnt_m[r] != 0) pop++;
    end
    obs_stall = b.StallD;
    obs_busy  = b.BusyVec;
    check_val("stall", 64'(b.StallD), 64'(exp_stall));
    check_val("busyvec", 64'(b.BusyVec), 64'(exp_busy));
    check_val("busycount", 64'(b.BusyCount), 64'(bc_m));
    check_val("stallcycles", 64'(b.StallCycles), 64'(sc_m));
    @(posedge clk);
    if (rst) begin
      foreach (cnt_m[r]) cnt_m[r] = 0;
      last_v_m = 0;
      bc_m = 0;
      sc_m = 0;
    end else begin
      bc_m = pop;
      if (exp_stall && sc_m < 64'hFFFF_FFFF) sc_m++;
      acc = b.IssueValidD && !exp_stall && b.RegWriteD && rd != 0 && lat != 0;
      for (int r = 1; r < NREG; r++) begin
        if (acc && r == rd)
          cnt_m[r] = (lat > MAX_LAT) ? MAX_LAT : lat;
        else if (b.FlushE && last_v_m && r == last_rd_m)
          cnt_m[r] = 0;
        else if (cnt_m[r] > 0)
          cnt_m[r] = cnt_m[r] - 1;
      end
      last_v_m  = acc;
      last_rd_m = rd;
    end
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    foreach (cnt_m[r]) cnt_m[r] = 0;
    last_v_m = 0; last_rd_m = 0; bc_m = 0; sc_m = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    idle(1);

    // RAW on x5 after a 3-cycle result.
    drive(1, 1, 5, 3, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 5, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_stall) n++; else break;
    end
    check_val("raw_x5_stall_len", 64'(n), 64'(3 - THR));
    idle(4);

    // Writes to x0 never mark anything busy.
    drive(1, 1, 0, 5, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    check_val("x0_stall", 64'(obs_stall), 64'(0));
    check_val("x0_busy", 64'(obs_busy), 64'(0));
    idle(2);

    // WAW on x7 holds until the earlier write drains.
    drive(1, 1, 7, 4, 0, 0, 0); tick();
    drive(1, 1, 7, 1, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_stall) n++; else break;
    end
    check_val("waw_x7_stall_len", 64'(n), 64'(4));
    idle(3);

    // Flush right after issuing x9 frees it.
    drive(1, 1, 9, 6, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 0, 0, 0, 0, 9, 0); tick();
    check_val("flush_x9_stall", 64'(obs_stall), 64'(0));
    check_val("flush_x9_busy", 64'(obs_busy[9]), 64'(0));
    idle(2);

    // Latency above MAX_LAT is clamped.
    drive(1, 1, 3, 15, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (obs_busy[3]) n++; else break;
    end
    check_val("clamp_x3_busy_len", 64'(n), 64'(MAX_LAT));
    idle(2);

    // Reset mid-countdown.
    drive(1, 1, 4, 5, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 4, 0, 0); tick();
    rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0; tick();
    check_val("rst_busy", 64'(obs_busy), 64'(0));
    check_val("rst_stallcycles", 64'(b.StallCycles), 64'(0));
    check_val("rst_busycount", 64'(b.BusyCount), 64'(0));

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 15),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 4) == 0);
      tick();
    end
    rst = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers tracked; register 0 is hardwired zero.
REQ-002 Parameter MAX_LAT, default 8: largest result latency in cycles that can be tracked.
REQ-003 Derived AW = clog2(NREG); LW = clog2(MAX_LAT+1).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 IssueValidD  in  1  the Decode instruction requests issue this cycle.
REQ-008 RegWriteD  in  1  the issuing instruction writes RdD.
REQ-009 RdD  in  AW  destination register of the issuing instruction.
REQ-010 LatD  in  LW  cycles until the result is usable; 0 means usable next cycle with no tracking.
REQ-011 Rs1D, Rs2D  in  AW each  source registers of the Decode instruction.
REQ-012 FlushE  in  1  squash the instruction issued on the previous cycle.
REQ-013 StallD  out  1  Decode must hold; when high, the issue is not accepted.
REQ-014 BusyVec  out  NREG  bit r is high when cnt[r] != 0.
REQ-015 BusyCount  out  AW+1  number of set BusyVec bits, registered.
REQ-016 StallCycles  out  32  saturating count of cycles with StallD high.

Function
REQ-017 Each register r SHALL hold a counter cnt[r] of width LW; cnt[0] SHALL stay 0 at all times.
REQ-018 Accept = IssueValidD & ~StallD & RegWriteD & (RdD != 0) & (LatD != 0); on accept, cnt[RdD] SHALL load min(LatD, MAX_LAT) at the next edge.
REQ-019 Every nonzero cnt[r] that is not being loaded SHALL decrement by 1 per cycle, saturating at 0.
REQ-020 A RAW hazard exists on source s when s != 0 and cnt[s] exceeds the availability threshold set in REQ-030 (Configuration).
REQ-021 A WAW hazard exists when IssueValidD & RegWriteD & (RdD != 0) & (cnt[RdD] != 0).
REQ-022 StallD SHALL be combinational and equal IssueValidD & (RAW on Rs1D | RAW on Rs2D | WAW).
REQ-023 The block SHALL register the last accepted RdD and a valid flag for exactly one cycle.
  - If FlushE is high and that flag is set, cnt[last RdD] SHALL clear to 0 at the next edge.
  - If FlushE is high and the flag is clear, FlushE SHALL have no effect.
REQ-024 If FlushE and a new accept target the same register in the same cycle, the new load SHALL win.
REQ-025 LatD > MAX_LAT SHALL be clamped to MAX_LAT; no wrap-around is permitted.
REQ-026 StallCycles SHALL increment once per StallD-high cycle and hold at 0xFFFFFFFF.
REQ-027 BusyCount SHALL reflect BusyVec from the previous cycle (one-cycle latency).

Reset
REQ-028 While rst is high at a clock edge, all cnt[], the last-issue flag, BusyCount and StallCycles SHALL clear to 0, including mid-countdown.
REQ-029 After reset, BusyVec = 0, and StallD SHALL depend only on the current inputs.

Configuration
REQ-030 Macro HAZARD_SCOREBOARD_FWD_EN:
  - When defined, a source is available when cnt <= 1, because the result is forwarded in its final cycle.
  - When undefined, a source is available only when cnt == 0 and no forwarding is assumed.
  - The WAW rule SHALL be identical in both builds.

Structure
REQ-031 Shared package hazard_pkg SHALL hold the NREG/MAX_LAT defaults, the LW/AW width functions, and the lat_t typedef.
REQ-032 A sub-module sb_entry SHALL implement one per-register load/decrement/clear counter; it SHALL be instantiated NREG-1 times through generate.

Verification
REQ-033 Issue x5 with LatD=3, then Rs1D=5 on the following cycles:
  - FWD_EN defined: StallD high for 2 cycles, then low.
  - FWD_EN undefined: StallD high for 3 cycles, then low.
REQ-034 Issue RdD=0 with LatD=5, then Rs1D=0 -> BusyVec stays 0 and StallD stays low.
REQ-035 Issue x7 with LatD=4, then next cycle issue RdD=7 with LatD=1 -> StallD high (WAW) until cnt[7]=0.
REQ-036 Issue x9 with LatD=6, then FlushE next cycle -> cnt[9]=0 one cycle later, and Rs2D=9 no longer stalls.
REQ-037 Issue x3 with LatD=15 (MAX_LAT=8) -> cnt[3] loads 8, and BusyVec[3] stays high for exactly 8 cycles.
REQ-038 Assert rst while cnt[4]=5 -> all outputs 0 next cycle, and StallCycles also returns to 0.
